// File: rtl/rot_ctrl_pkg.sv
// Shared definitions for the rotation control path: clock rate, default operand
// widths and the sweep sequencer state encoding.
package rot_ctrl_pkg;

    // System clock shared with the PWM stage.
    localparam int unsigned ROT_CLK_HZ  = 100_000_000;

    // Default operand widths.
    localparam int unsigned ROT_MS_W    = 16;
    localparam int unsigned ROT_STEP_W  = 8;

    // Sweep sequencer states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTurn  = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } sweep_state_e;

    // Clocks per millisecond tick for a given clock frequency.
    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Clearable millisecond prescaler. Counts 0..CLK_HZ/1000-1 and asserts tick
// during the last count, so the first tick after a clear arrives exactly
// CLK_HZ/1000 clocks later.
module ms_tick_gen
    import rot_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ = ROT_CLK_HZ
) (
    input  logic clk,
    input  logic rst,   // asynchronous, active-low
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = ms_div(CLK_HZ);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the final count of each period.
    assign tick = (cnt_q == LAST);

    // Next count: clear wins, wrap on tick, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/horizontal_sweep_ctrl.sv
// Timed sweep sequencer feeding the horizontal rotation PWM stage. A start
// runs STEPS phases of (turn high ON_MS, turn low OFF_MS) and then pulses done.
// Operands are latched at start; abort drops back to idle without done.
module horizontal_sweep_ctrl
    import rot_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ = ROT_CLK_HZ,
    parameter int unsigned MS_W   = ROT_MS_W,
    parameter int unsigned STEP_W = ROT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active-low
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] steps,
    input  logic [MS_W-1:0]   on_ms,
    input  logic [MS_W-1:0]   off_ms,
    output logic              turn,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt
);

    sweep_state_e state_q, state_d;

    logic [STEP_W-1:0] steps_l_q;
    logic [MS_W-1:0]   on_ms_l_q;
    logic [MS_W-1:0]   off_ms_l_q;
    logic [MS_W-1:0]   ms_q;
    logic [MS_W-1:0]   ms_inc;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_inc;

    logic turn_q, turn_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic tick;
    logic enter;      // a transition is taken this cycle (including TURN->TURN)
    logic accept;     // start accepted: latch operands
    logic phase_end;  // a turn phase completes: count it
    logic presc_clr;

    assign ms_inc   = ms_q + MS_W'(1);
    assign step_inc = step_q + STEP_W'(1);

    // Hold the prescaler cleared while idle and restart it on every state entry.
    assign presc_clr = enter || (state_q == StIdle);

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other decision.
    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        accept    = 1'b0;
        phase_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (steps != '0) && (on_ms != '0)) begin
                    state_d = StTurn;
                    enter   = 1'b1;
                    accept  = 1'b1;
                end
            end
            StTurn: begin
                // The tick that brings the ms count to on_ms ends the phase.
                if (tick && (ms_inc == on_ms_l_q)) begin
                    phase_end = 1'b1;
                    enter     = 1'b1;
                    if (step_inc == steps_l_q) begin
                        state_d = StDone;
                    end else if (off_ms_l_q == '0) begin
                        state_d = StTurn;
                    end else begin
                        state_d = StPause;
                    end
                end
            end
            StPause: begin
                if (tick && (ms_inc == off_ms_l_q)) begin
                    state_d = StTurn;
                    enter   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                enter   = 1'b1;
            end
            default: begin
                state_d = StIdle;
                enter   = 1'b1;
            end
        endcase
        if (abort) begin
            state_d   = StIdle;
            enter     = 1'b1;
            accept    = 1'b0;
            phase_end = 1'b0;
        end
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        turn_d = (state_d == StTurn);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turn_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            turn_q <= turn_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operand latches, loaded only when a run is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            steps_l_q  <= '0;
            on_ms_l_q  <= '0;
            off_ms_l_q <= '0;
        end else if (accept) begin
            steps_l_q  <= steps;
            on_ms_l_q  <= on_ms;
            off_ms_l_q <= off_ms;
        end
    end

    // Millisecond counter: restarts on every state entry, advances on ticks while timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_q <= '0;
        end else if (enter) begin
            ms_q <= '0;
        end else if (tick && ((state_q == StTurn) || (state_q == StPause))) begin
            ms_q <= ms_inc;
        end
    end

    // Completed-step counter: zeroed at start, holds its value across abort and idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= '0;
        end else if (accept) begin
            step_q <= '0;
        end else if (phase_end) begin
            step_q <= step_inc;
        end
    end

    assign turn     = turn_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_q;

endmodule
